moving_average_scheduler: RTL and testbench

MOVING_AVERAGE_SCHEDULER -- requirements
Module: moving_average_scheduler

---
 rtl/functions_pkg.sv | 16 +
 rtl/moving_average_pkg.sv | 25 ++
 rtl/round_robin_arbiter.sv | 33 +++
 rtl/moving_average_scheduler.sv | 138 +++++++++++++
 tb/tb_moving_average_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/functions_pkg.sv
// Shared constant helper functions used for parameter-derived widths.
package functions_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/moving_average_pkg.sv
// Width derivation and FSM state type shared by the moving-average scheduler.
package moving_average_pkg;
    import functions_pkg::*;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic int min1_clog2(input int value);
        int r;
        r = clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ch_width(input int num_channels);
        return min1_clog2(num_channels);
    endfunction

    function automatic int addr_width(input int num_channels, input int window_size);
        return min1_clog2(num_channels * window_size);
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_rr_ptr wins.
module round_robin_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        int              cand;
        logic [IW-1:0]   w_c;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = 0;
        w_c     = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(i_rr_ptr) + k;
            if (cand >= N) cand = cand - N;
            w_c = IW'(cand);
            if (!o_valid && i_req[w_c]) begin
                o_valid      = 1'b1;
                o_grant[w_c] = 1'b1;
                o_idx        = w_c;
            end
        end
    end

endmodule

// File: rtl/moving_average_scheduler.sv
// Arbitrates per-channel samples onto a shared moving-average datapath and
// tracks each channel's window write pointer and fill level.
//   state    | meaning
//   ST_RUN   | normal arbitration and issue
//   ST_DRAIN | clear pending: no grants, wait for output stage to empty
//   ST_CLEAR | zero pointers of target channel(s), pulse clear_done
module moving_average_scheduler
    import moving_average_pkg::*;
#(
    parameter  int NUM_CHANNELS = 4,
    parameter  int WINDOW_SIZE  = 8,
    parameter  int DATA_SIZE    = 16,
    localparam int CH_W         = ch_width(NUM_CHANNELS),
    localparam int ADDR_W       = addr_width(NUM_CHANNELS, WINDOW_SIZE)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CHANNELS-1:0]        in_valid,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0] in_data,
    output logic [NUM_CHANNELS-1:0]        in_ready,
    input  logic                           clear_req,
    input  logic                           clear_all,
    input  logic [CH_W-1:0]                clear_channel,
    output logic                           clear_done,
    output logic                           dp_valid,
    input  logic                           dp_ready,
    output logic [CH_W-1:0]                dp_channel,
    output logic [DATA_SIZE-1:0]           dp_data,
    output logic [ADDR_W-1:0]              dp_addr,
    output logic                           dp_window_full
);

    localparam int WP_W = min1_clog2(WINDOW_SIZE);
    localparam int FC_W = min1_clog2(WINDOW_SIZE + 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CH_W-1:0]         r_rr_ptr;
    logic [WP_W-1:0]         r_wp [NUM_CHANNELS];
    logic [FC_W-1:0]         r_fc [NUM_CHANNELS];
    logic                    r_clr_all;
    logic [CH_W-1:0]         r_clr_ch;

    logic [NUM_CHANNELS-1:0] w_grant;
    logic [CH_W-1:0]         w_gidx;
    logic                    w_gvalid;
    logic                    w_grant_en;
    logic                    w_xfer;
    logic [DATA_SIZE-1:0]    w_gdata;

    round_robin_arbiter #(
        .N  (NUM_CHANNELS),
        .IW (CH_W)
    ) u_arb (
        .i_req    (in_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_gidx),
        .o_valid  (w_gvalid)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (clear_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!dp_valid || dp_ready) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Reset gates the combinational outputs so nothing is offered or reported mid-reset.
    always_comb begin
        w_grant_en = (r_state == ST_RUN) && !clear_req && !reset && (!dp_valid || dp_ready);
        in_ready   = w_grant_en ? w_grant : '0;
        clear_done = (r_state == ST_CLEAR) && !reset;
    end

    assign w_xfer = w_gvalid && |(in_valid & in_ready);

    always_comb begin
        w_gdata = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_gidx == CH_W'(c)) w_gdata = in_data[c*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_clr_all      <= 1'b0;
            r_clr_ch       <= '0;
            dp_valid       <= 1'b0;
            dp_channel     <= '0;
            dp_data        <= '0;
            dp_addr        <= '0;
            dp_window_full <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wp[c] <= '0;
                r_fc[c] <= '0;
            end
        end else begin
            if (w_xfer) begin
                dp_valid       <= 1'b1;
                dp_channel     <= w_gidx;
                dp_data        <= w_gdata;
                dp_addr        <= ADDR_W'(w_gidx) * ADDR_W'(WINDOW_SIZE) + ADDR_W'(r_wp[w_gidx]);
                dp_window_full <= (r_fc[w_gidx] == FC_W'(WINDOW_SIZE));
                r_rr_ptr       <= (w_gidx == CH_W'(NUM_CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
            end else if (dp_ready) begin
                dp_valid <= 1'b0;
            end

            if (r_state == ST_RUN && clear_req) begin
                r_clr_all <= clear_all;
                r_clr_ch  <= clear_channel;
            end

            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_xfer && w_gidx == CH_W'(c)) begin
                    r_wp[c] <= (r_wp[c] == WP_W'(WINDOW_SIZE - 1)) ? '0 : r_wp[c] + 1'b1;
                    if (r_fc[c] != FC_W'(WINDOW_SIZE)) r_fc[c] <= r_fc[c] + 1'b1;
                end
                // An out-of-range clear_channel matches no c and clears nothing.
                if (r_state == ST_CLEAR && (r_clr_all || r_clr_ch == CH_W'(c))) begin
                    r_wp[c] <= '0;
                    r_fc[c] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_average_scheduler.sv
// Directed scenarios plus randomized traffic, checked against a behavioural model.
module tb_moving_average_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 16;

    logic          clk;
    logic          reset;
    logic [N-1:0]  in_valid;
    logic [N*D-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          clear_req;
    logic          clear_all;
    logic [1:0]    clear_channel;
    logic          clear_done;
    logic          dp_valid;
    logic          dp_ready;
    logic [1:0]    dp_channel;
    logic [D-1:0]  dp_data;
    logic [4:0]    dp_addr;
    logic          dp_window_full;

    moving_average_scheduler #(
        .NUM_CHANNELS (N),
        .WINDOW_SIZE  (W),
        .DATA_SIZE    (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .clear_req      (clear_req),
        .clear_all      (clear_all),
        .clear_channel  (clear_channel),
        .clear_done     (clear_done),
        .dp_valid       (dp_valid),
        .dp_ready       (dp_ready),
        .dp_channel     (dp_channel),
        .dp_data        (dp_data),
        .dp_addr        (dp_addr),
        .dp_window_full (dp_window_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: mode 0 = run, 1 = drain, 2 = clear
    int m_mode, m_rr, m_dv, m_ch, m_data, m_addr, m_full, m_clr_all, m_clr_ch;
    int m_wp [N];
    int m_fc [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock: check combinational outputs, step the model, check registered outputs.
    task automatic tick();
        int   g;
        int   c;
        int   old_dv;
        logic [N-1:0] exp_rdy;
        logic exp_done;
        #2;
        g = -1;
        if (!reset && m_mode == 0 && !clear_req && (m_dv == 0 || dp_ready)) begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (g < 0 && in_valid[c]) g = c;
            end
        end
        exp_rdy  = (g >= 0) ? N'(1 << g) : '0;
        exp_done = (m_mode == 2) && !reset;
        chk("in_ready", in_ready, exp_rdy);
        chk("clear_done", clear_done, exp_done);

        old_dv = m_dv;
        if (reset) begin
            m_mode = 0; m_rr = 0; m_dv = 0; m_ch = 0; m_data = 0; m_addr = 0; m_full = 0;
            for (int k = 0; k < N; k++) begin m_wp[k] = 0; m_fc[k] = 0; end
        end else begin
            if (g >= 0) begin
                m_dv    = 1;
                m_ch    = g;
                m_data  = int'(in_data[g*D +: D]);
                m_addr  = g * W + m_wp[g];
                m_full  = (m_fc[g] == W) ? 1 : 0;
                m_wp[g] = (m_wp[g] + 1) % W;
                if (m_fc[g] < W) m_fc[g]++;
                m_rr    = (g + 1) % N;
            end else if (dp_ready) begin
                m_dv = 0;
            end
            case (m_mode)
                0: if (clear_req) begin
                       m_clr_all = int'(clear_all);
                       m_clr_ch  = int'(clear_channel);
                       m_mode    = 1;
                   end
                1: if (old_dv == 0 || dp_ready) m_mode = 2;
                default: begin
                    for (int k = 0; k < N; k++)
                        if (m_clr_all != 0 || m_clr_ch == k) begin m_wp[k] = 0; m_fc[k] = 0; end
                    m_mode = 0;
                end
            endcase
        end

        @(posedge clk);
        #1;
        chk("dp_valid", dp_valid, m_dv);
        chk("dp_channel", dp_channel, m_ch);
        chk("dp_data", dp_data, m_data);
        chk("dp_addr", dp_addr, m_addr);
        chk("dp_window_full", dp_window_full, m_full);
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_data = '0; clear_req = 1'b0; clear_all = 1'b0;
        clear_channel = '0; dp_ready = 1'b1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        m_mode = 0; m_rr = 0; m_dv = 0; m_ch = 0; m_data = 0; m_addr = 0; m_full = 0;
        m_clr_all = 0; m_clr_ch = 0;
        for (int k = 0; k < N; k++) begin m_wp[k] = 0; m_fc[k] = 0; end
        @(posedge clk);
        #1;
        reset_dut();
        chk("reset_dp_valid", dp_valid, 0);
        chk("reset_dp_addr", dp_addr, 0);

        // All channels valid: grants rotate 0,1,2,3,0 with continuous issue
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_data = {$urandom(), $urandom()};
            tick();
            chk("rr_seq_ch", dp_channel, i % 4);
            chk("rr_seq_valid", dp_valid, 1);
        end

        // Channel 2 alone, 9 samples: window wraps and becomes full
        reset_dut();
        in_valid = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            in_data = {$urandom(), $urandom()};
            tick();
            chk("ch2_addr", dp_addr, 16 + (i % 8));
            chk("ch2_full", dp_window_full, (i == 8) ? 1 : 0);
        end

        // Output stall for 3 cycles
        reset_dut();
        in_valid = 4'hF;
        in_data = {$urandom(), $urandom()};
        tick();
        tick();
        dp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ch", dp_channel, 1);
        end
        dp_ready = 1'b1;
        tick();
        chk("post_stall_ch", dp_channel, 2);

        // Clear channel 1 while all valid and output stalled
        reset_dut();
        in_valid = 4'hF;
        in_data = {$urandom(), $urandom()};
        tick();
        tick();
        dp_ready = 1'b0;
        tick();
        clear_req = 1'b1; clear_all = 1'b0; clear_channel = 2'd1;
        tick();
        clear_req = 1'b0; clear_channel = 2'd0;
        tick();
        tick();
        dp_ready = 1'b1;
        tick();
        #2;
        chk("clr1_done", clear_done, 1);
        tick();
        in_valid = 4'b0010;
        tick();
        chk("clr1_addr", dp_addr, 8);
        chk("clr1_full", dp_window_full, 0);
        in_valid = 4'b0001;
        tick();
        chk("clr1_keep_ch0", dp_addr, 1);

        // Clear all mid-stream
        reset_dut();
        in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
        clear_req = 1'b1; clear_all = 1'b1;
        tick();
        clear_req = 1'b0; clear_all = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom(), $urandom()};
            tick();
            chk("clrall_addr", dp_addr, ((2 + i) % 4) * 8);
            chk("clrall_full", dp_window_full, 0);
        end

        // Reset during DRAIN
        reset_dut();
        in_valid = 4'hF;
        tick();
        dp_ready = 1'b0;
        clear_req = 1'b1; clear_channel = 2'd2;
        tick();
        clear_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_drain_dv", dp_valid, 0);
        reset = 1'b0;
        dp_ready = 1'b1;
        tick();
        chk("rst_drain_first_ch", dp_channel, 0);
        chk("rst_drain_first_dv", dp_valid, 1);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("rst_drain_no_done", clear_done, 0);
            tick();
        end

        // Randomized traffic
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            in_valid      = 4'($urandom());
            in_data       = {$urandom(), $urandom()};
            dp_ready      = ($urandom_range(0, 3) != 0);
            clear_req     = ($urandom_range(0, 15) == 0);
            clear_all     = 1'($urandom());
            clear_channel = 2'($urandom());
            reset         = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
